// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/writeback sequencer.
// Owns pc, the instruction register, the ALU start and register-file write
// strobes, the retire pulse and the halt state. The decoder sits outside
// and reads opcode combinationally; its answer comes back on dec_*.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for run; all strobes low
// FETCH     | imem_req high at address pc until imem_ack
// DECODE    | decoder looks at ir; NOP, jump and HALT retire here
// EXECUTE   | alu_start on the first cycle, wait for ex_done
// WRITEBACK | rf_we (if the decoder asks for it), retire, pc+1
// HALT      | halted high; only rst leaves
module core_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [5:0]         opcode,
  input  logic [1:0]         dec_inst_type,
  input  logic               dec_reg_write,
  output logic               alu_start,
  input  logic               ex_done,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc,
  output logic               retire,
  output logic               halted,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] T_NOP  = 2'b00;
  localparam logic [1:0] T_IMM  = 2'b01;
  localparam logic [1:0] T_ALU  = 2'b10;
  localparam logic [1:0] T_JUMP = 2'b11;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 ex_first_q;
  logic                 is_halt;
  logic [PC_W-1:0]      pc_inc;
  state_t               after_retire;

  assign opcode       = ir_q[INSTR_W-1 -: 6];
  assign is_halt      = (opcode == OP_HALT);
  assign pc_inc       = pc_q + PC_W'(1);
  // run is only looked at when an instruction completes
  assign after_retire = run ? S_FETCH : S_IDLE;

  // State, pc and ir registers; ex_first_q marks the first EXECUTE cycle
  // so alu_start stays a registered, state-decoded pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ex_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ex_first_q <= (state_d == S_EXECUTE) && (state_q != S_EXECUTE);
    end
  end

  // Next-state, next-pc and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          case (dec_inst_type)
            T_NOP: begin
              pc_d    = pc_inc;
              state_d = after_retire;
            end
            T_IMM:  state_d = S_WRITEBACK;
            T_ALU:  state_d = S_EXECUTE;
            T_JUMP: begin
              pc_d    = ir_q[PC_W-1:0];
              state_d = after_retire;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_EXECUTE: begin
        if (ex_done) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_inc;
        state_d = after_retire;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; nothing looks at imem_ack.
  always_comb begin
    imem_req  = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH:     imem_req  = 1'b1;
      S_DECODE:    retire    = is_halt || (dec_inst_type == T_NOP) ||
                               (dec_inst_type == T_JUMP);
      S_EXECUTE:   alu_start = ex_first_q;
      S_WRITEBACK: begin
        rf_we  = dec_reg_write;
        retire = 1'b1;
      end
      S_HALT:      halted    = 1'b1;
      default:     ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed program runs against an instruction-level
// reference model, with per-cycle compares and hand-computed spot checks.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] ir;
  logic [5:0]  opcode;
  logic [1:0]  dec_inst_type;
  logic        dec_reg_write;
  logic        alu_start;
  logic        ex_done = 1'b0;
  logic        rf_we;
  logic [7:0]  pc;
  logic        retire;
  logic        halted;
  logic [2:0]  state;

  core_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .ir(ir), .opcode(opcode),
    .dec_inst_type(dec_inst_type), .dec_reg_write(dec_reg_write),
    .alu_start(alu_start), .ex_done(ex_done), .rf_we(rf_we), .pc(pc),
    .retire(retire), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // decoder table: {inst_type, reg_write}
  function automatic logic [2:0] dec_tab(input logic [5:0] op);
    case (op)
      6'b001110: return 3'b011;   // LDIM
      6'b100000: return 3'b101;   // ALU
      6'b110000: return 3'b110;   // JUMP
      default:   return 3'b000;   // NOP and HALT
    endcase
  endfunction

  assign {dec_inst_type, dec_reg_write} = dec_tab(opcode);

  logic [15:0] mem [256];
  int          wait_of [256];
  int          ex_wait = 2;
  bit          toggle = 1'b0;

  // instruction memory: ack after wait_of[addr] stall cycles
  int fcnt = 0;
  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      imem_data = mem[imem_addr];
      if (fcnt >= wait_of[imem_addr]) begin imem_ack = 1'b1; fcnt = 0; end
      else begin imem_ack = 1'b0; fcnt++; end
    end else begin
      fcnt = 0;
      imem_ack = toggle ? ~imem_ack : 1'b0;
    end
  end

  // execute unit: ex_done after ex_wait extra cycles
  int ecnt = 0;
  always @(posedge clk) begin
    #2;
    if (state == 3'd3) begin
      if (ecnt >= ex_wait) begin ex_done = 1'b1; ecnt = 0; end
      else begin ex_done = 1'b0; ecnt++; end
    end else begin
      ex_done = 1'b0;
      ecnt = 0;
    end
  end

  // reference model: phase numbers as the spec lists them, m_age counts
  // cycles spent in the phase
  int          m_phase = 0;
  int          m_age = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int nxt;
    logic [2:0] k;
    bit done;
    if (rst) begin
      m_phase = 0; m_pc = 8'h00; m_ir = 16'h0000; m_age = 0; m_valid = 1'b1;
    end else begin
      nxt = m_phase;
      k = dec_tab(m_ir[15:10]);
      done = 1'b0;
      if (m_phase == 0 && run) nxt = 1;
      else if (m_phase == 1 && imem_ack) begin m_ir = imem_data; nxt = 2; end
      else if (m_phase == 2) begin
        if (m_ir[15:10] == 6'h3f) nxt = 5;
        else if (k[2:1] == 2'b01) nxt = 4;
        else if (k[2:1] == 2'b10) nxt = 3;
        else if (k[2:1] == 2'b11) begin m_pc = m_ir[7:0]; done = 1'b1; end
        else begin m_pc = 8'((int'(m_pc) + 1) % 256); done = 1'b1; end
      end
      else if (m_phase == 3 && ex_done) nxt = 4;
      else if (m_phase == 4) begin m_pc = 8'((int'(m_pc) + 1) % 256); done = 1'b1; end
      if (done) nxt = run ? 1 : 0;
      m_age = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cnt_retire = 0, cnt_rf = 0, cnt_alu = 0, cnt_req = 0, cnt_ex = 0, cnt_req5 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    logic [2:0] k;
    logic [5:0] op;
    bit exp_ret;
    op = m_ir[15:10];
    k = dec_tab(op);
    exp_ret = (m_phase == 2 && (op == 6'h3f || k[2:1] == 2'b00 || k[2:1] == 2'b11))
              || m_phase == 4;
    chk("state",     32'(state),     32'(m_phase));
    chk("pc",        32'(pc),        32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("ir",        32'(ir),        32'(m_ir));
    chk("opcode",    32'(opcode),    32'(op));
    chk("imem_req",  32'(imem_req),  32'(m_phase == 1));
    chk("alu_start", 32'(alu_start), 32'(m_phase == 3 && m_age == 0));
    chk("rf_we",     32'(rf_we),     32'(m_phase == 4 && k[0]));
    chk("retire",    32'(retire),    32'(exp_ret));
    chk("halted",    32'(halted),    32'(m_phase == 5));
    cnt_retire += int'(retire);
    cnt_rf     += int'(rf_we);
    cnt_alu    += int'(alu_start);
    cnt_req    += int'(imem_req);
    cnt_ex     += int'(state == 3'd3);
    cnt_req5   += int'(imem_req && imem_addr == 8'h05);
  endtask

  // advance n cycles, comparing at every negedge; returns 2 after a posedge
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (m_valid) cycle_check();
      @(posedge clk);
    end
    #2;
  endtask

  task automatic wait_sp(input string name, input int s, input int p, input int budget);
    int n = 0;
    while (!(int'(state) == s && (p < 0 || int'(pc) == p)) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  int b_ret, b_rf, b_alu, b_ex, b_req5, b_req;

  initial begin
    rst = 1'b1; run = 1'b0;
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; wait_of[i] = 0; end
    mem[5] = 16'h3812; wait_of[5] = 3;
    mem[6] = 16'h8034;
    mem[7] = 16'hC0FF;
    mem[8'hFF] = 16'hC0A0;
    mem[8'hA0] = 16'h0000;
    mem[8'hA1] = 16'h8034;
    tick(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_halted", 32'(halted), 0);

    // NOPs at 0..4, then LDIM at 5 with a three-cycle ack delay
    rst = 1'b0; run = 1'b1;
    b_ret = cnt_retire; b_rf = cnt_rf;
    wait_sp("wait_pc5", 1, 5, 60);
    chk("nop_retires", 32'(cnt_retire - b_ret), 5);
    chk("nop_rf_we", 32'(cnt_rf - b_rf), 0);
    chk("nop_pc", 32'(pc), 5);
    b_ret = cnt_retire; b_rf = cnt_rf; b_req5 = cnt_req5;
    wait_sp("wait_ldim_dec", 2, -1, 20);
    chk("ldim_fetch_cycles", 32'(cnt_req5 - b_req5), 4);
    chk("ldim_ir", 32'(ir), 32'h3812);
    chk("ldim_opcode", 32'(opcode), 32'b001110);
    wait_sp("wait_pc6", 1, 6, 20);
    chk("ldim_rf_we", 32'(cnt_rf - b_rf), 1);
    chk("ldim_retire", 32'(cnt_retire - b_ret), 1);

    // ALU with ex_done two cycles late
    b_ret = cnt_retire; b_rf = cnt_rf; b_alu = cnt_alu; b_ex = cnt_ex;
    wait_sp("wait_pc7", 1, 7, 20);
    chk("alu_start_pulses", 32'(cnt_alu - b_alu), 1);
    chk("alu_ex_cycles", 32'(cnt_ex - b_ex), 3);
    chk("alu_rf_we", 32'(cnt_rf - b_rf), 1);
    chk("alu_retire", 32'(cnt_retire - b_ret), 1);

    // jump to FF, then jump from FF to A0
    wait_sp("wait_pcff", 1, 8'hFF, 20);
    chk("jump_ff_addr", 32'(imem_addr), 32'hFF);
    wait_sp("wait_pca0", 1, 8'hA0, 20);
    chk("jump_a0_addr", 32'(imem_addr), 32'hA0);

    // drop run while the ALU at A1 executes
    wait_sp("wait_exec_a1", 3, -1, 20);
    run = 1'b0;
    b_ret = cnt_retire;
    wait_sp("wait_idle_a1", 0, -1, 20);
    chk("drop_run_pc", 32'(pc), 32'hA2);
    chk("drop_run_retire", 32'(cnt_retire - b_ret), 1);
    tick(3);
    chk("idle_stays", 32'(state), 0);

    // pc wrap: NOP at FF
    rst = 1'b1;
    tick(2);
    mem[0] = 16'hC0FF; mem[8'hFF] = 16'h0000;
    rst = 1'b0; run = 1'b1;
    wait_sp("wait_wrap_ff", 1, 8'hFF, 20);
    wait_sp("wait_wrap_00", 1, 0, 20);
    chk("wrap_addr", 32'(imem_addr), 0);
    run = 1'b0;
    wait_sp("wait_wrap_idle", 0, -1, 20);
    chk("wrap_idle_pc", 32'(pc), 32'hFF);

    // HALT at 9
    rst = 1'b1;
    tick(2);
    for (int i = 0; i < 9; i++) mem[i] = 16'h0000;
    mem[9] = 16'hFC00;
    rst = 1'b0; run = 1'b1;
    b_ret = cnt_retire;
    wait_sp("wait_halt", 5, -1, 60);
    chk("halt_pc", 32'(pc), 9);
    chk("halt_flag", 32'(halted), 1);
    toggle = 1'b1;
    b_req = cnt_req;
    tick(20);
    chk("halt_no_req", 32'(cnt_req - b_req), 0);
    chk("halt_retires", 32'(cnt_retire - b_ret), 10);
    chk("halt_pc_held", 32'(pc), 9);
    toggle = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("halt_rst_state", 32'(state), 0);
    chk("halt_rst_pc", 32'(pc), 0);
    chk("halt_rst_flag", 32'(halted), 0);

    // reset in FETCH with ack arriving the same cycle
    mem[0] = 16'h3812;
    rst = 1'b0; run = 1'b1;
    tick(1);
    chk("fetch_req_before_rst", 32'(imem_req), 1);
    rst = 1'b1;
    tick(1);
    chk("fetch_rst_state", 32'(state), 0);
    chk("fetch_rst_req", 32'(imem_req), 0);
    chk("fetch_rst_ir", 32'(ir), 0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the EyeArch core. Fetches instructions from instruction memory over a req/ack handshake, holds them in an instruction register, presents the opcode to the combinational decoder, and steps the datapath through EXECUTE and WRITEBACK according to the decoded instruction type. Owns the program counter, the register-file write strobe, the ALU start strobe and the halt state.

## Interface

Parameters:
- PC_W, 8, program counter and instruction address width
- INSTR_W, 16, instruction width; opcode is ir[INSTR_W-1:INSTR_W-6]

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  enable; sequencer leaves IDLE only while high
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  fetch accepted; imem_data valid in same cycle
- imem_data  in  INSTR_W  fetched instruction word
- ir  out  INSTR_W  instruction register
- opcode  out  6  ir[INSTR_W-1:INSTR_W-6], to decoder
- dec_inst_type  in  2  decoder instruction type
- dec_reg_write  in  1  decoder register-write enable
- alu_start  out  1  one-cycle pulse on EXECUTE entry
- ex_done  in  1  multi-cycle execute complete
- rf_we  out  1  register-file write strobe
- pc  out  PC_W  program counter
- retire  out  1  one-cycle pulse on instruction completion
- halted  out  1  high in HALT
- state  out  3  current FSM state encoding (debug)

## Operation

- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- IDLE: all strobes low; run=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; imem_addr held stable while req high. Cycle with imem_ack=1: ir<=imem_data, -> DECODE. imem_ack while not in FETCH ignored.
- DECODE: decoder driven combinationally from ir; transitions:
  - opcode 6'b111111 (HALT): retire=1, pc unchanged, -> HALT.
  - inst_type 00 (NOP): retire=1, pc<=pc+1, -> next.
  - inst_type 01 (immediate, e.g. LDIM): -> WRITEBACK.
  - inst_type 10 (ALU): -> EXECUTE.
  - inst_type 11 (jump): retire=1, pc<=ir[PC_W-1:0], -> next.
- EXECUTE: alu_start=1 on first cycle only; stay until ex_done=1 (ex_done on first cycle accepted), then -> WRITEBACK.
- WRITEBACK: rf_we=dec_reg_write, retire=1, pc<=pc+1, -> next.
- "next" = FETCH if run=1, else IDLE. run is sampled only at retire and in IDLE; dropping run mid-instruction completes that instruction.
- HALT: halted=1, no requests, exits only via rst.
- pc+1 wraps modulo 2^PC_W (all-ones -> 0).

## Timing

- Reset values: state=IDLE, pc=0, ir=0, imem_req=0, alu_start=0, rf_we=0, retire=0, halted=0; opcode=0.
- imem_req, alu_start, rf_we, retire, halted are Moore-decoded from state (rf_we also gated by dec_reg_write); no output depends combinationally on imem_ack.
- Zero-wait memory (ack in first FETCH cycle): NOP/jump 2 cycles, immediate 3 cycles, ALU 4+N cycles (N = extra cycles waiting for ex_done).
- Each wait cycle with ack low adds one FETCH cycle; req stays high, address unchanged.
- rst asserted in any state, including FETCH with req high or EXECUTE awaiting ex_done: next cycle all outputs at reset values; pending ack/ex_done discarded.
- Exactly one retire pulse per instruction, including HALT.

## Test plan

- Reset then run=1, memory returns NOP (opcode 000000, type 00) with immediate ack at pc 0..3 -> retire every 2 cycles, pc 0->1->2->3->4, rf_we never high.
- LDIM (opcode 001110, type 01, reg_write=1) at pc 5 with ack delayed 3 cycles -> imem_addr=5 stable over 4 FETCH cycles, rf_we=1 for exactly one cycle in WRITEBACK, retire same cycle, pc=6.
- ALU op type 10 with ex_done after 2 extra cycles -> alu_start one pulse, EXECUTE lasts 3 cycles, then WRITEBACK, pc+1.
- Jump type 11 with ir[7:0]=0xA0 at pc 0xFF -> pc=0xA0 after DECODE; separately NOP at pc 0xFF -> pc wraps to 0x00.
- HALT opcode 111111 at pc 9 -> single retire, halted=1, pc stays 9, no further imem_req for 20 cycles despite run=1 and ack toggling; rst -> IDLE, pc=0.
- rst asserted in FETCH with req high and ack arriving same cycle -> ir stays 0, next cycle state=IDLE and imem_req=0; run dropped in EXECUTE -> instruction completes, retire, then IDLE.
